// File: rtl/debounce_pkg.sv
// Shared defaults and legal parameter ranges for the debounce bank.
// Optional long-press/auto-repeat logic is enabled with DEBOUNCE_HOLD_EN.
package debounce_pkg;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_CNT_W         = 14;
   localparam int DEF_DEBOUNCE_TIME = 16382;
   localparam int DEF_TICK_DIV      = 1;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_HOLD_TIME     = 1000;
   localparam int DEF_REPEAT_TIME   = 250;

   localparam int MIN_N_CH          = 1;
   localparam int MAX_N_CH          = 32;
   localparam int MIN_SYNC_STAGES   = 2;
   localparam int MAX_SYNC_STAGES   = 4;
   localparam int MIN_TICK_DIV      = 1;
   localparam int MIN_DEBOUNCE_TIME = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced button channel: synchroniser, stability counter, level, edge pulses.
// Long-press/auto-repeat pulses on hold exist only when DEBOUNCE_HOLD_EN is defined.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int CNT_W         = DEF_CNT_W,
   parameter int DEBOUNCE_TIME = DEF_DEBOUNCE_TIME,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int HOLD_TIME     = DEF_HOLD_TIME,
   parameter int REPEAT_TIME   = DEF_REPEAT_TIME
)(
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic button_in,
   output logic button_out,
   output logic rise,
   output logic fall,
   output logic hold
);

   if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
      $fatal(1, "debounce_ch: SYNC_STAGES out of range");
   end
   if (DEBOUNCE_TIME < MIN_DEBOUNCE_TIME ||
       longint'(DEBOUNCE_TIME) > (longint'(1) << CNT_W) - 1) begin : g_bad_time
      $fatal(1, "debounce_ch: DEBOUNCE_TIME out of range for CNT_W");
   end
   if (HOLD_TIME < 1 || REPEAT_TIME < 1) begin : g_bad_hold
      $fatal(1, "debounce_ch: HOLD_TIME and REPEAT_TIME must be at least 1");
   end

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TIME - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_in;
   logic [CNT_W-1:0]       count;
   logic                   accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
   end

   assign sync_in = sync_q[SYNC_STAGES-1];
   assign accept  = (sync_in != button_out) && tick && (count == LAST);

   // Any sample agreeing with the accepted level restarts the stability count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         button_out <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync_in == button_out) begin
            count <= '0;
         end else if (accept) begin
            button_out <= sync_in;
            count      <= '0;
            rise       <= sync_in;
            fall       <= !sync_in;
         end else if (tick) begin
            count <= count + 1'b1;
         end
      end
   end

`ifdef DEBOUNCE_HOLD_EN
   localparam int HOLD_W = $clog2(max_int(HOLD_TIME, REPEAT_TIME) + 1);

   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_target;
   logic              repeating;

   assign hold_target = repeating ? HOLD_W'(REPEAT_TIME - 1) : HOLD_W'(HOLD_TIME - 1);

   // First pulse after HOLD_TIME ticks of a held press, then every REPEAT_TIME ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         repeating <= 1'b0;
         hold      <= 1'b0;
      end else begin
         hold <= 1'b0;
         if (!button_out || accept) begin
            hold_cnt  <= '0;
            repeating <= 1'b0;
         end else if (tick) begin
            if (hold_cnt == hold_target) begin
               hold      <= 1'b1;
               hold_cnt  <= '0;
               repeating <= 1'b1;
            end else begin
               hold_cnt <= hold_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign hold = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH independent debounced buttons sharing one tick prescaler.
// Define DEBOUNCE_HOLD_EN to enable long-press/auto-repeat pulses on hold.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int CNT_W         = DEF_CNT_W,
   parameter int DEBOUNCE_TIME = DEF_DEBOUNCE_TIME,
   parameter int TICK_DIV      = DEF_TICK_DIV,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int HOLD_TIME     = DEF_HOLD_TIME,
   parameter int REPEAT_TIME   = DEF_REPEAT_TIME
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] button_in,
   output logic [N_CH-1:0] button_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] hold
);

   if (N_CH < MIN_N_CH || N_CH > MAX_N_CH) begin : g_bad_nch
      $fatal(1, "debounce_bank: N_CH out of range");
   end
   if (TICK_DIV < MIN_TICK_DIV) begin : g_bad_div
      $fatal(1, "debounce_bank: TICK_DIV must be at least 1");
   end

   logic tick;

   if (TICK_DIV == 1) begin : g_no_div
      assign tick = 1'b1;
   end else begin : g_div
      localparam int PW = $clog2(TICK_DIV);
      localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

      logic [PW-1:0] pre;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)               pre <= '0;
         else if (pre == PRE_LAST) pre <= '0;
         else                      pre <= pre + 1'b1;
      end

      assign tick = (pre == PRE_LAST);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .CNT_W         (CNT_W),
         .DEBOUNCE_TIME (DEBOUNCE_TIME),
         .SYNC_STAGES   (SYNC_STAGES),
         .HOLD_TIME     (HOLD_TIME),
         .REPEAT_TIME   (REPEAT_TIME)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .tick       (tick),
         .button_in  (button_in[i]),
         .button_out (button_out[i]),
         .rise       (rise[i]),
         .fall       (fall[i]),
         .hold       (hold[i])
      );
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed self-checking bench for debounce_bank (DEBOUNCE_TIME=8, SYNC_STAGES=2).
// Hold pulse timing is checked when DEBOUNCE_HOLD_EN is defined, otherwise hold must stay 0.
module tb_debounce_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_n_div;
   logic [3:0] button_in;
   logic [3:0] button_out;
   logic [3:0] rise;
   logic [3:0] fall;
   logic [3:0] hold;
   logic [3:0] button_in_div;
   logic [3:0] button_out_div;
   logic [3:0] rise_div;
   logic [3:0] fall_div;
   logic [3:0] hold_div;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   debounce_bank #(
      .N_CH(4), .CNT_W(14), .DEBOUNCE_TIME(8), .TICK_DIV(1), .SYNC_STAGES(2),
      .HOLD_TIME(20), .REPEAT_TIME(5)
   ) dut (
      .clk(clk), .rst_n(rst_n), .button_in(button_in), .button_out(button_out),
      .rise(rise), .fall(fall), .hold(hold)
   );

   debounce_bank #(
      .N_CH(4), .CNT_W(14), .DEBOUNCE_TIME(8), .TICK_DIV(4), .SYNC_STAGES(2),
      .HOLD_TIME(20), .REPEAT_TIME(5)
   ) dut_div (
      .clk(clk), .rst_n(rst_n_div), .button_in(button_in_div), .button_out(button_out_div),
      .rise(rise_div), .fall(fall_div), .hold(hold_div)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] value);
      button_in = value;
   endtask

   // Every action and sample happens 1 time unit after a rising edge.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   int         first_hi, rise_cnt, rise_edge;
   int         r2_edge, r3_edge, r2_cnt, r3_cnt, f2_edge, f3_edge;
   logic [13:0] others;
   logic [2:0]  acc3;
   logic [3:0]  acc4;
`ifdef DEBOUNCE_HOLD_EN
   int hoff [3];
   int hcnt, rise_at, fall_seen, late_holds;
`endif

   initial begin
      rst_n         = 1'b0;
      rst_n_div     = 1'b0;
      button_in     = 4'b0000;
      button_in_div = 4'b0000;
      repeat (3) stepClock();
      checkOutput("reset_button_out", int'(button_out), 0);
      checkOutput("reset_pulses", int'({rise, fall, hold}), 0);
      rst_n = 1'b1;

      // Single press on ch0: level and rise after edge 10.
      applyStimulus(4'b0001);
      first_hi = 0; rise_cnt = 0; rise_edge = 0; others = '0;
      for (int e = 1; e <= 14; e++) begin
         stepClock();
         if (button_out[0] && first_hi == 0) first_hi = e;
         if (rise[0]) begin rise_cnt++; rise_edge = e; end
         others |= {button_out[3:1], rise[3:1], fall, hold};
      end
      checkOutput("ch0_latency", first_hi, 10);
      checkOutput("ch0_rise_edge", rise_edge, 10);
      checkOutput("ch0_rise_count", rise_cnt, 1);
      checkOutput("ch0_others_quiet", int'(others != '0), 0);

      // Bouncing ch1: 3-clock toggles never reach the 8-tick threshold.
      acc3 = '0;
      for (int seg = 0; seg < 10; seg++) begin
         button_in[1] = (seg % 2 == 0);
         repeat (3) begin
            stepClock();
            acc3 |= {button_out[1], rise[1], fall[1]};
         end
      end
      button_in[1] = 1'b0;
      repeat (15) begin
         stepClock();
         acc3 |= {button_out[1], rise[1], fall[1]};
      end
      checkOutput("ch1_bounce_quiet", int'(acc3), 0);
      checkOutput("ch0_level_kept", int'(button_out[0]), 1);

      // Simultaneous press and release on ch2/ch3.
      applyStimulus(4'b1101);
      r2_edge = 0; r3_edge = 0; r2_cnt = 0; r3_cnt = 0;
      for (int e = 1; e <= 14; e++) begin
         stepClock();
         if (rise[2]) begin r2_cnt++; r2_edge = e; end
         if (rise[3]) begin r3_cnt++; r3_edge = e; end
      end
      checkOutput("ch2_rise_edge", r2_edge, 10);
      checkOutput("ch3_rise_edge", r3_edge, 10);
      checkOutput("ch23_rise_count", r2_cnt + r3_cnt, 2);
      applyStimulus(4'b0001);
      f2_edge = 0; f3_edge = 0; acc4 = '0;
      for (int e = 1; e <= 14; e++) begin
         stepClock();
         if (fall[2]) f2_edge = e;
         if (fall[3]) f3_edge = e;
         acc4 |= {fall[1:0], rise[1:0]};
      end
      checkOutput("ch2_fall_edge", f2_edge, 10);
      checkOutput("ch3_fall_edge", f3_edge, 10);
      checkOutput("ch01_no_pulse", int'(acc4), 0);
      checkOutput("levels_after_release", int'(button_out), 1);

      // Asynchronous reset clears a set level without waiting for a clock.
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_clear_level", int'(button_out), 0);
      stepClock();
      rst_n = 1'b1;

      // Reset in the middle of a pending press discards progress.
      repeat (6) stepClock();
      checkOutput("pending_not_done", int'(button_out[0]), 0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_count_outputs", int'({button_out, rise, fall, hold}), 0);
      acc4 = '0;
      repeat (6) begin
         stepClock();
         acc4 |= button_out | rise | fall | hold;
      end
      checkOutput("no_pulse_in_reset", int'(acc4), 0);
      rst_n = 1'b1;
      first_hi = 0; rise_cnt = 0;
      for (int e = 1; e <= 14; e++) begin
         stepClock();
         if (button_out[0] && first_hi == 0) first_hi = e;
         if (rise[0]) rise_cnt++;
      end
      checkOutput("post_reset_latency", first_hi, 10);
      checkOutput("post_reset_rise_count", rise_cnt, 1);

      // Prescaled instance: 8 ticks of 4 clocks after the synchroniser.
      rst_n_div     = 1'b1;
      button_in_div = 4'b0001;
      first_hi = 0; rise_cnt = 0; rise_edge = 0; others = '0;
      for (int e = 1; e <= 40; e++) begin
         stepClock();
         if (button_out_div[0] && first_hi == 0) first_hi = e;
         if (rise_div[0]) begin rise_cnt++; rise_edge = e; end
         others |= {button_out_div[3:1], rise_div[3:1], fall_div, hold_div};
      end
      checkOutput("tdiv_latency_window", int'(first_hi >= 32 && first_hi <= 35), 1);
      checkOutput("tdiv_rise_count", rise_cnt, 1);
      checkOutput("tdiv_rise_with_level", rise_edge, first_hi);
      checkOutput("tdiv_others_quiet", int'(others != '0), 0);

`ifdef DEBOUNCE_HOLD_EN
      // Long press: hold at +20, then every 5 ticks; nothing after release.
      applyStimulus(4'b0000);
      #2 rst_n = 1'b0;
      stepClock();
      rst_n = 1'b1;
      applyStimulus(4'b0001);
      rise_at = 0; hcnt = 0;
      for (int k = 1; k <= 60; k++) begin
         stepClock();
         if (rise[0] && rise_at == 0) rise_at = k;
         if (hold[0] && rise_at != 0 && hcnt < 3) begin
            hoff[hcnt] = k - rise_at;
            hcnt++;
         end
      end
      checkOutput("hold_count", hcnt, 3);
      checkOutput("hold_first", hoff[0], 20);
      checkOutput("hold_repeat1", hoff[1], 25);
      checkOutput("hold_repeat2", hoff[2], 30);
      applyStimulus(4'b0000);
      fall_seen = 0;
      for (int k = 1; k <= 20 && fall_seen == 0; k++) begin
         stepClock();
         if (fall[0]) fall_seen = 1;
      end
      checkOutput("hold_fall_seen", fall_seen, 1);
      late_holds = 0;
      repeat (30) begin
         stepClock();
         if (hold[0]) late_holds++;
      end
      checkOutput("hold_none_after_fall", late_holds, 0);
`else
      // ch0 is held high here; with the feature off hold must never pulse.
      acc4 = '0;
      repeat (40) begin
         stepClock();
         acc4 |= hold;
      end
      checkOutput("hold_tied_zero", int'(acc4), 0);
      checkOutput("hold_press_level", int'(button_out[0]), 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
